reg_write_ctrl: RTL and testbench

REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

---
 rtl/reg_write_ctrl.sv | 86 ++++++++
 tb/tb_reg_write_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reg_write_ctrl.sv
// Register file with an in-order write buffer: writes are queued and retired
// one per cycle when commit_en allows, while reads forward the newest queued value.
module reg_write_ctrl #(
   parameter int DW    = 16,
   parameter int AW    = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [AW-1:0]              wr_addr,
   input  logic [DW-1:0]              wr_data,
   input  logic                       commit_en,
   input  logic [AW-1:0]              op1,
   input  logic [AW-1:0]              op2,
   output logic [DW-1:0]              op1_out,
   output logic [DW-1:0]              op2_out,
   output logic [$clog2(DEPTH):0]     pending
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int NREG = 1 << AW;

   logic [DW-1:0] regs     [NREG];
   logic [AW-1:0] buf_addr [DEPTH];
   logic [DW-1:0] buf_data [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          accept;
   logic          commit;
   logic [DW-1:0] fwd1;
   logic [DW-1:0] fwd2;

   assign wr_ready = (count < CW'(DEPTH));
   assign pending  = count;
   assign accept   = wr_valid && wr_ready;
   assign commit   = commit_en && (count != '0);

   // Walk the buffer oldest to newest so the last matching entry wins; the
   // entry being accepted this edge is not yet in the buffer and is ignored.
   always_comb begin
      logic [PW-1:0] idx;
      idx  = '0;
      fwd1 = regs[op1];
      fwd2 = regs[op2];
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count) begin
            if (buf_addr[idx] == op1) fwd1 = buf_data[idx];
            if (buf_addr[idx] == op2) fwd2 = buf_data[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) regs[r] <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         op1_out <= '0;
         op2_out <= '0;
      end else begin
         if (accept) begin
            buf_addr[tail] <= wr_addr;
            buf_data[tail] <= wr_data;
            tail           <= tail + 1'b1;
         end
         if (commit) begin
            regs[buf_addr[head]] <= buf_data[head];
            head                 <= head + 1'b1;
         end
         case ({accept, commit})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         op1_out <= fwd1;
         op2_out <= fwd2;
      end
   end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed self-checking bench for reg_write_ctrl with hand-computed expectations.
module tb_reg_write_ctrl;

   logic        clk;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        commit_en;
   logic [3:0]  op1;
   logic [3:0]  op2;
   logic [15:0] op1_out;
   logic [15:0] op2_out;
   logic [2:0]  pending;

   int checkCount;
   int errorCount;

   reg_write_ctrl #(.DW(16), .AW(4), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .commit_en (commit_en),
      .op1       (op1),
      .op2       (op2),
      .op1_out   (op1_out),
      .op2_out   (op2_out),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [15:0] d, input logic c);
      wr_valid  = v;
      wr_addr   = a;
      wr_data   = d;
      commit_en = c;
      tick();
   endtask

   initial begin
      checkCount = 0;
      errorCount = 0;
      rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      commit_en = 1'b0; op1 = '0; op2 = '0;
      tick();
      tick();
      checkOutput("reset_pending", 32'(pending), 0);
      checkOutput("reset_op1", 32'(op1_out), 0);
      checkOutput("reset_op2", 32'(op2_out), 0);
      rst_n = 1'b1;
      tick();
      checkOutput("ready_after_reset", 32'(wr_ready), 1);

      // Basic write then read
      applyStimulus(1'b1, 4'd3, 16'h0008, 1'b1);
      checkOutput("basic_pending1", 32'(pending), 1);
      op1 = 4'd3;
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("basic_op1", 32'(op1_out), 32'h0008);
      checkOutput("basic_pending0", 32'(pending), 0);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("commit_empty_noop", 32'(pending), 0);
      checkOutput("basic_op1_reg", 32'(op1_out), 32'h0008);

      // Fill and backpressure
      for (int a = 1; a <= 4; a++) applyStimulus(1'b1, 4'(a), 16'(a * 16'h11), 1'b0);
      checkOutput("full_pending", 32'(pending), 4);
      checkOutput("full_ready", 32'(wr_ready), 0);
      applyStimulus(1'b1, 4'd6, 16'h0066, 1'b0);
      checkOutput("blocked_pending", 32'(pending), 4);
      op1 = 4'd1; op2 = 4'd6;
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("pop_pending", 32'(pending), 3);
      checkOutput("pop_ready", 32'(wr_ready), 1);
      checkOutput("pop_fwd_op1", 32'(op1_out), 32'h0011);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0);
      checkOutput("reg1_written", 32'(op1_out), 32'h0011);
      checkOutput("reg6_untouched", 32'(op2_out), 0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("drain_pending", 32'(pending), 0);
      op1 = 4'd4;
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0);
      checkOutput("reg4_written", 32'(op1_out), 32'h0044);

      // Forwarding newest entry to same address
      applyStimulus(1'b1, 4'd5, 16'h0038, 1'b0);
      applyStimulus(1'b1, 4'd5, 16'h1234, 1'b0);
      op2 = 4'd5;
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0);
      checkOutput("fwd_newest", 32'(op2_out), 32'h1234);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("fwd_during_commit", 32'(op2_out), 32'h1234);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("fwd_partial_drain", 32'(op2_out), 32'h1234);
      checkOutput("fwd_drained", 32'(pending), 0);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0);
      checkOutput("reg5_final", 32'(op2_out), 32'h1234);

      // Simultaneous accept and commit to one address: ordering visible via forwarding
      op1 = 4'd8;
      applyStimulus(1'b1, 4'd8, 16'h0001, 1'b0);
      applyStimulus(1'b1, 4'd8, 16'h0002, 1'b0);
      checkOutput("sim_pending_start", 32'(pending), 2);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 4'd8, 16'(k + 3), 1'b1);
         checkOutput("sim_pending", 32'(pending), 2);
         checkOutput("sim_fwd", 32'(op1_out), 32'(k + 2));
      end
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("sim_drain1", 32'(pending), 1);
      checkOutput("sim_fwd_last", 32'(op1_out), 32'h0005);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("sim_drain0", 32'(pending), 0);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0);
      checkOutput("sim_reg8", 32'(op1_out), 32'h0005);

      // Reset mid-operation discards buffered writes
      applyStimulus(1'b1, 4'd2, 16'hBEEF, 1'b0);
      applyStimulus(1'b1, 4'd9, 16'hCAFE, 1'b0);
      applyStimulus(1'b1, 4'd10, 16'hF00D, 1'b0);
      checkOutput("pre_reset_pending", 32'(pending), 3);
      rst_n = 1'b0; op1 = 4'd2; op2 = 4'd5;
      applyStimulus(1'b1, 4'd11, 16'hFFFF, 1'b1);
      checkOutput("mid_reset_pending", 32'(pending), 0);
      checkOutput("mid_reset_op1", 32'(op1_out), 0);
      checkOutput("mid_reset_op2", 32'(op2_out), 0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("mid_reset_ready", 32'(wr_ready), 1);
      for (int a = 0; a < 16; a++) begin
         op1 = 4'(a);
         op2 = 4'(15 - a);
         applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
         checkOutput("cleared_op1", 32'(op1_out), 0);
         checkOutput("cleared_op2", 32'(op2_out), 0);
      end

      // Same-edge accept is not forwarded
      op1 = 4'd7; op2 = 4'd7;
      applyStimulus(1'b1, 4'd7, 16'hAAAA, 1'b1);
      checkOutput("same_edge_op1", 32'(op1_out), 0);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
      checkOutput("next_edge_op1", 32'(op1_out), 32'hAAAA);
      checkOutput("equal_addr_op2", 32'(op2_out), 32'hAAAA);
      applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0);
      checkOutput("reg7_committed", 32'(op1_out), 32'hAAAA);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
